ni_flit_tx_link: RTL
====================

// Module: ni_flit_tx_link
// PURPOSE
//  Downstream neighbour of ni_transmit_control in the NI transmit path.
//  - Takes the per-flit valid and flit_counter from the transmit controller.
//  - Selects the indexed flit from the parallel message bus, tags it head/tail,
//    registers it onto the NoC output link, and enforces credit-based flow control.
//  - Returns stall to the controller whenever no downstream credit is available.
// PARAMETERS
//  FLITWD      32   payload bits per flit (excl. 2 type bits)
//  MAXFLITS    8    max flits per message; msg_in holds MAXFLITS*FLITWD bits
//  CNTWD       3    flit index width; equals `COUNTERFLITWD, >= clog2(MAXFLITS)
//  CREDITS     4    downstream input-buffer depth = credit counter reset value
//  CRWD        3    credit counter width, >= clog2(CREDITS+1)
// PORTS
//  clk              in   1                 clock, all logic on rising edge
//  rst              in   1                 synchronous reset, active-low (0 = reset)
//  msg_in           in   MAXFLITS*FLITWD   message; flit i = msg_in[i*FLITWD +: FLITWD]
//  num_flit         in   CNTWD             flits in current message (1..MAXFLITS)
//  tx_valid         in   1                 transmit-controller valid: send flit now
//  flit_counter     in   CNTWD             index of flit offered this cycle
//  stall            out  1                 to controller: no credit available
//  link_flit        out  FLITWD+2          {type[1:0],payload}; type[1]=head, type[0]=tail
//  link_valid       out  1                 link_flit valid this cycle
//  credit_in        in   1                 one credit returned by downstream router
//  pkt_active       out  1                 head sent, tail not yet sent
//  credit_err       out  1                 sticky: credit returned with counter full
// BEHAVIOUR
//  Reset (rst==0 at a clock edge), all outputs and state:
//  - link_flit=0, link_valid=0, credits=CREDITS, state=IDLE, credit_err=0.
//  - stall=0 follows immediately, since credits!=0.
//  stall:
//  - Combinational: stall = (credits==0). Driven from registers only, no loop via tx_valid.
//  Send, fire = tx_valid && !stall:
//  - Next edge: link_flit <= {head,tail,msg_in[flit_counter*FLITWD +: FLITWD]}, link_valid <= 1.
//  - Otherwise link_valid <= 0 (one-cycle pulse per flit; link_flit holds last value).
//  - Latency 1 cycle from fire to link_valid.
//  - head = (flit_counter==0); tail = (flit_counter==num_flit-1).
//  - num_flit==1 gives type 2'b11.
//  - tx_valid while stall=1: ignored, no flit, no credit change.
//    The controller must hold its counter (it does, since valid is gated by stall).
//  Credits, per cycle:
//  - fire&&!credit_in: -1.
//  - credit_in&&!fire: +1.
//  - both: unchanged.
//  - credit_in with credits==CREDITS and no fire: counter stays, credit_err <= 1 (sticky until reset).
//  - Underflow impossible: fire requires credits>0.
//  FSM, 2 states:
//  - IDLE: fire with head&&!tail -> ACTIVE.
//  - IDLE: single-flit fire stays IDLE.
//  - ACTIVE: fire with tail -> IDLE.
//  - pkt_active = (state==ACTIVE).
//  - Fire of a head flit while ACTIVE (protocol violation): flit still sent,
//    state stays ACTIVE, no error flagged. This is left to assertions in the bench.
//  - flit_counter >= MAXFLITS: payload forced 0; verification flags it as illegal stimulus.
//  Reset mid-packet:
//  - Everything returns to reset values; a partially sent packet is abandoned.
//    Upstream reset is the system's job.
//  - Credits re-initialise to CREDITS; the downstream router must be reset together.
// STRUCTURE
//  Shared package / noc_parameters.v:
//  - `COUNTERFLITWD
//  - flit type encodings FT_HEAD=2'b10, FT_BODY=2'b00, FT_TAIL=2'b01, FT_SINGLE=2'b11
//  - FSM state constants ST_IDLE/ST_ACTIVE
//  One sub-module: ni_credit_counter. Holds the up/down saturating counter,
//  the zero flag (stall) and the sticky overflow flag.
//  Flit mux, typing and FSM stay in the top level.
// TESTING
//  1. Reset then num_flit=3, tx_valid on 3 cycles with counter 0,1,2, credit_in=0:
//     link_valid pulses x3 with types 10,00,01; credits 4->1; stall=0 throughout.
//  2. CREDITS=4, 6-flit message, no credit_in: after 4 fires stall=1.
//     Flits 4,5 are withheld. One credit_in pulse -> stall=0 next cycle -> flit 4 sent, stall=1 again.
//  3. num_flit=1, fire: link_flit type 11, payload msg_in[FLITWD-1:0]; pkt_active stays 0.
//  4. fire and credit_in in the same cycle at credits=2: credits stays 2; link_valid=1 next cycle.
//  5. credit_in at credits=4 idle: credits stays 4, credit_err=1 and holds.
//     rst=0 for one edge clears it.
//  6. rst=0 after flit 1 of a 4-flit packet: next cycle link_valid=0, pkt_active=0, credits=4.
//     The restarted message is sent from head.

Source files
------------

// File: rtl/ni_flit_tx_link_pkg.sv
// Shared constants for the NI transmit link: flit counter width, flit type codes, FSM states.
package ni_flit_tx_link_pkg;

  localparam int unsigned COUNTERFLITWD = 3;

  localparam logic [1:0] FT_HEAD   = 2'b10;
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b01;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_ACTIVE
  } link_state_e;

endpackage

// File: rtl/ni_credit_counter.sv
// Up/down credit counter for the NoC output link: zero flag drives stall, sticky flag on overflow.
module ni_credit_counter #(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CRWD    = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic dec_i,
  input  logic inc_i,
  output logic zero_o,
  output logic err_o
);

  logic [CRWD-1:0] count_q, count_d;
  logic            err_q, err_d;

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (dec_i && !inc_i) begin
      count_d = count_q - CRWD'(1);
    end else if (inc_i && !dec_i) begin
      // A returned credit with the counter already full means the downstream lost sync.
      if (count_q == CRWD'(CREDITS)) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + CRWD'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= CRWD'(CREDITS);
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign err_o  = err_q;

endmodule

// File: rtl/ni_flit_tx_link.sv
// NI transmit link: selects and types the indexed flit, registers it onto the link,
// and throttles the transmit controller with credit-based flow control.
module ni_flit_tx_link
  import ni_flit_tx_link_pkg::*;
#(
  parameter int unsigned FLITWD   = 32,
  parameter int unsigned MAXFLITS = 8,
  parameter int unsigned CNTWD    = COUNTERFLITWD,
  parameter int unsigned CREDITS  = 4,
  parameter int unsigned CRWD     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MAXFLITS*FLITWD-1:0]   msg_in,
  input  logic [CNTWD-1:0]             num_flit,
  input  logic                         tx_valid,
  input  logic [CNTWD-1:0]             flit_counter,
  output logic                         stall,
  output logic [FLITWD+1:0]            link_flit,
  output logic                         link_valid,
  input  logic                         credit_in,
  output logic                         pkt_active,
  output logic                         credit_err
);

  logic              fire, head, tail;
  logic [1:0]        flit_type;
  logic [FLITWD-1:0] payload;

  logic [FLITWD+1:0] link_flit_q, link_flit_d;
  logic              link_valid_q, link_valid_d;
  link_state_e       state_q, state_d;

  ni_credit_counter #(
    .CREDITS (CREDITS),
    .CRWD    (CRWD)
  ) u_credit (
    .clk_i  (clk),
    .rst_ni (rst),
    .dec_i  (fire),
    .inc_i  (credit_in),
    .zero_o (stall),
    .err_o  (credit_err)
  );

  assign fire = tx_valid && !stall;
  assign head = (flit_counter == '0);
  assign tail = (flit_counter == num_flit - CNTWD'(1));

  // Indices with no matching flit slot leave the payload at zero.
  always_comb begin
    payload = '0;
    for (int unsigned i = 0; i < MAXFLITS; i++) begin
      if (flit_counter == CNTWD'(i)) begin
        payload = msg_in[i*FLITWD +: FLITWD];
      end
    end
  end

  always_comb begin
    unique case ({head, tail})
      2'b11:   flit_type = FT_SINGLE;
      2'b10:   flit_type = FT_HEAD;
      2'b01:   flit_type = FT_TAIL;
      default: flit_type = FT_BODY;
    endcase
  end

  always_comb begin
    link_flit_d  = link_flit_q;
    link_valid_d = 1'b0;
    state_d      = state_q;
    if (fire) begin
      link_flit_d  = {flit_type, payload};
      link_valid_d = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (fire && head && !tail) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (fire && tail) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      link_flit_q  <= '0;
      link_valid_q <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      link_flit_q  <= link_flit_d;
      link_valid_q <= link_valid_d;
      state_q      <= state_d;
    end
  end

  assign link_flit  = link_flit_q;
  assign link_valid = link_valid_q;
  assign pkt_active = (state_q == ST_ACTIVE);

endmodule
